bus_decoder_ctrl: RTL and testbench
===================================

Name: bus_decoder_ctrl

Overview:
- Parametrised, registered peripheral bus decoder between the core's load/store unit and N memory-mapped slaves: RAM, LEDs, HEX and further devices.
- Accepts one master request at a time and matches the address against per-slave base/mask windows.
- Forwards the request to the selected slave and holds it until that slave returns ready.
- Returns read data and an error flag to the master with a single-cycle valid pulse.
- Unmapped addresses complete with an error response instead of a silent RAM access.

Parameters:
N_SLAVES, 4, number of slave ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h8000_2000, 32'h8000_1000, 32'h8000_0800, 32'h0000_0000}, packed N_SLAVES*ADDR_W base addresses, slave 0 in LSBs
SLV_MASK, {32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FF00}, packed N_SLAVES*ADDR_W match masks
TIMEOUT_CYCLES, 16, slave response limit (used only with optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  master request
- we_i  in  1  master write enable
- addr_i  in  ADDR_W  master address
- wdata_i  in  DATA_W  master write data
- be_i  in  DATA_W/8  master byte enables
- busy_o  out  1  decoder occupied; master holds off new requests
- rvalid_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_W  read data, valid with rvalid_o
- err_o  out  1  error completion, valid with rvalid_o
- slv_req_o  out  N_SLAVES  one-hot slave request
- slv_we_o  out  1  latched write enable
- slv_addr_o  out  ADDR_W  latched address
- slv_wdata_o  out  DATA_W  latched write data
- slv_be_o  out  DATA_W/8  latched byte enables
- slv_ready_i  in  N_SLAVES  per-slave ready/ack
- slv_rdata_i  in  N_SLAVES*DATA_W  packed per-slave read data, slave 0 in LSBs

Behaviour:
- Reset: state IDLE.
  - busy_o, rvalid_o, err_o and slv_req_o are 0.
  - rdata_o, slv_addr_o, slv_wdata_o, slv_be_o and slv_we_o are 0.
- Address match: slave k hits when (addr_i & SLV_MASK[k]) == (SLV_BASE[k] & SLV_MASK[k]).
  - On multiple hits, the lowest index wins.
  - Matching is evaluated on the raw addr_i; the latched address is forwarded unmodified.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE, no request: busy_o=0.
- IDLE, req_i=1, accept cycle T:
  - Latch we, addr, wdata, be and the selected index.
  - Hit: go to ACCESS.
  - Miss: go to ERR.
  - busy_o rises at T+1.
- ACCESS:
  - slv_req_o[sel]=1, all other bits 0.
  - Held with stable latched signals until slv_ready_i[sel]=1.
  - Then capture slv_rdata_i[sel] into rdata_o and go to RESP.
  - Ready bits from non-selected slaves are ignored.
  - Minimum latency: accept at T, slv_req at T+1, ready at T+1, rvalid_o at T+2.
- RESP:
  - rvalid_o=1, err_o=0 for exactly one cycle, then IDLE.
  - rdata_o holds its value until the next completion.
  - For writes, rdata_o is captured too (don't-care contents).
- ERR:
  - rvalid_o=1, err_o=1, rdata_o=0 for one cycle, then IDLE.
  - No slv_req_o asserted.
- busy_o = (state != IDLE).
  - req_i while busy_o=1 is ignored; the master must hold or re-issue it.
  - The first request may be accepted in the cycle after rvalid_o.
- rst_i in any state returns to IDLE on the next edge and drops slv_req_o immediately (registered, same edge).
  - No rvalid_o is issued for the aborted transaction.
- Single outstanding transaction; no pipelining of requests.

Optional Feature:
- Macro: BUS_DECODER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on ACCESS entry and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES with no ready, drop slv_req_o and go to ERR (err_o=1, rdata_o=0).
  - Ready arriving in the same cycle as the count hit wins, giving a normal RESP.
- Not defined: no counter; ACCESS waits indefinitely for slv_ready_i.

Test Plan:
- Read 0x0000_0010, slave 0 ready at T+1 with rdata 0xDEAD_BEEF -> slv_req_o=4'b0001 at T+1; rvalid_o=1, err_o=0, rdata_o=0xDEAD_BEEF at T+2.
- Write 0x8000_0801 data 0x0000_00A5, slave 1 ready after 3 wait cycles -> slv_req_o=4'b0010 held 4 cycles with addr 0x8000_0801 and wdata 0x0000_00A5 stable; one rvalid_o pulse; busy_o low next cycle.
- Read 0x4000_0000 (unmapped) -> no slv_req_o; rvalid_o=1, err_o=1, rdata_o=0 at T+2.
- Overlap check with SLV_BASE[0]=SLV_BASE[1]=0x0 and masks 0xFFFF_FF00, read 0x0000_0004 -> slv_req_o=4'b0001 only.
- rst_i asserted in ACCESS with slave never ready -> next edge slv_req_o=0, busy_o=0, no rvalid_o; a following read of 0x8000_1000 completes normally via slave 2.
- With BUS_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave 3 never ready on read 0x8000_2040 -> slv_req_o[3] high for 16 cycles, then rvalid_o=1, err_o=1.

Source files
------------

// File: rtl/bus_decoder_ctrl.sv
// bus_decoder_ctrl: registered base/mask peripheral decoder with error completion for unmapped addresses.
// Optional slave response timeout is enabled by defining BUS_DECODER_TIMEOUT_EN.
module bus_decoder_ctrl #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h8000_2000, 32'h8000_1000, 32'h8000_0800, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FF00},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        be_i,
  output logic                       busy_o,
  output logic                       rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       err_o,
  output logic [N_SLAVES-1:0]        slv_req_o,
  output logic                       slv_we_o,
  output logic [ADDR_W-1:0]          slv_addr_o,
  output logic [DATA_W-1:0]          slv_wdata_o,
  output logic [DATA_W/8-1:0]        slv_be_o,
  input  logic [N_SLAVES-1:0]        slv_ready_i,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata_i
);
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  state_t state;
  logic [SW-1:0] sel, hit_idx;
  logic hit, sel_ready, timeout;
  assign busy_o = state != IDLE;
  assign sel_ready = slv_ready_i[sel];
  // Address window match; scanning downwards lets the lowest matching index win
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--)
      if ((addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == (SLV_BASE[k*ADDR_W +: ADDR_W] & SLV_MASK[k*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        hit_idx = SW'(k);
      end
  end
`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  // Counts unanswered ACCESS cycles; zero whenever not waiting on a slave
  always_ff @(posedge clk_i)
    if (rst_i) cnt <= '0;
    else cnt <= (state == ACCESS && !sel_ready) ? cnt + 1'b1 : '0;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  // Transaction FSM; all master and slave facing outputs are registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      sel <= '0;
      slv_req_o <= '0;
      slv_we_o <= 1'b0;
      slv_addr_o <= '0;
      slv_wdata_o <= '0;
      slv_be_o <= '0;
      rvalid_o <= 1'b0;
      err_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          sel <= hit_idx;
          slv_we_o <= we_i;
          slv_addr_o <= addr_i;
          slv_wdata_o <= wdata_i;
          slv_be_o <= be_i;
          slv_req_o <= hit ? N_SLAVES'(1) << hit_idx : '0;
          state <= hit ? ACCESS : ERR;
        end
        ACCESS: if (sel_ready) begin
          slv_req_o <= '0;
          rdata_o <= slv_rdata_i[sel*DATA_W +: DATA_W];
          rvalid_o <= 1'b1;
          err_o <= 1'b0;
          state <= RESP;
        end else if (timeout) begin
          slv_req_o <= '0;
          state <= ERR;
        end
        ERR: begin
          rvalid_o <= 1'b1;
          err_o <= 1'b1;
          rdata_o <= '0;
          state <= RESP;
        end
        default: begin
          rvalid_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_decoder_ctrl.sv
// tb_bus_decoder_ctrl: randomized and directed checks of bus_decoder_ctrl against an address-window model.
module tb_bus_decoder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0] be, ready;
  logic [127:0] rdata_bus;
  logic busy, rvalid, err, swe;
  logic [31:0] rdata, saddr, swdata;
  logic [3:0] sreq, sbe;
  logic d2_busy, d2_rvalid, d2_err, d2_swe;
  logic [31:0] d2_rdata, d2_saddr, d2_swdata;
  logic [3:0] d2_sreq, d2_sbe;
  int vectors = 0, miscompares = 0;
  logic [31:0] base1 [4] = '{32'h0000_0000, 32'h8000_0800, 32'h8000_1000, 32'h8000_2000};
  logic [31:0] mask1 [4] = '{32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_F000};
  logic [31:0] base2 [4] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_1000, 32'h8000_2000};
  logic [31:0] mask2 [4] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_F000};

  bus_decoder_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .busy_o(busy), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .slv_req_o(sreq), .slv_we_o(swe),
    .slv_addr_o(saddr), .slv_wdata_o(swdata), .slv_be_o(sbe), .slv_ready_i(ready), .slv_rdata_i(rdata_bus)
  );

  bus_decoder_ctrl #(
    .SLV_BASE({32'h8000_2000, 32'h8000_1000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FF00, 32'hFFFF_FF00})
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .busy_o(d2_busy), .rvalid_o(d2_rvalid), .rdata_o(d2_rdata), .err_o(d2_err), .slv_req_o(d2_sreq), .slv_we_o(d2_swe),
    .slv_addr_o(d2_saddr), .slv_wdata_o(d2_swdata), .slv_be_o(d2_sbe), .slv_ready_i(4'hF), .slv_rdata_i(rdata_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a, input bit second);
    for (int k = 0; k < 4; k++)
      if (second ? ((a & mask2[k]) == (base2[k] & mask2[k])) : ((a & mask1[k]) == (base1[k] & mask1[k])))
        return k;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int s);
    return s < 0 ? 32'd0 : 32'd1 << s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input int wait_n, input logic [31:0] rv);
    int s, s2;
    logic [31:0] d2_exp;
    s = decode(a, 1'b0);
    s2 = decode(a, 1'b1);
    rdata_bus = {$urandom, $urandom, $urandom, $urandom};
    if (s >= 0) rdata_bus[s*32 +: 32] = rv;
    d2_exp = s2 < 0 ? 32'd0 : rdata_bus[s2*32 +: 32];
    req = 1'b1; we = w; addr = a; wdata = d; be = b; ready = 4'h0;
    step();
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    chk("d2_slv_req", {28'd0, d2_sreq}, onehot(s2));
    if (s >= 0) begin
      for (int i = 0; i <= wait_n; i++) begin
        chk("slv_req", {28'd0, sreq}, onehot(s));
        chk("slv_addr", saddr, a);
        chk("slv_wdata", swdata, d);
        chk("slv_be", {28'd0, sbe}, {28'd0, b});
        chk("slv_we", {31'd0, swe}, {31'd0, w});
        chk("busy_access", {31'd0, busy}, 32'd1);
        chk("rvalid_access", {31'd0, rvalid}, 32'd0);
        ready = (i == wait_n) ? (4'($urandom) | 4'(onehot(s))) : (4'($urandom) & ~4'(onehot(s)));
        step();
      end
    end else begin
      chk("err_no_slv_req", {28'd0, sreq}, 32'd0);
      chk("busy_err", {31'd0, busy}, 32'd1);
      chk("rvalid_err", {31'd0, rvalid}, 32'd0);
      step();
    end
    ready = 4'h0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("err", {31'd0, err}, {31'd0, s < 0});
    if (!w || s < 0) chk("rdata", rdata, s < 0 ? 32'd0 : rv);
    chk("busy_resp", {31'd0, busy}, 32'd1);
    chk("slv_req_resp", {28'd0, sreq}, 32'd0);
    if (s < 0 || wait_n == 0) begin
      chk("d2_rvalid", {31'd0, d2_rvalid}, 32'd1);
      chk("d2_err", {31'd0, d2_err}, {31'd0, s2 < 0});
      if (!w || s2 < 0) chk("d2_rdata", d2_rdata, d2_exp);
    end
    step();
    chk("rvalid_done", {31'd0, rvalid}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; ready = '0; rdata_bus = '0;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_slv_req", {28'd0, sreq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_slv_addr", saddr, 32'd0);
    chk("rst_slv_wdata", swdata, 32'd0);
    chk("rst_slv_be", {28'd0, sbe}, 32'd0);
    chk("rst_slv_we", {31'd0, swe}, 32'd0);
    chk("rst_d2_busy", {31'd0, d2_busy}, 32'd0);
    rst = 1'b0;
    step();
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
    do_txn(1'b1, 32'h8000_0801, 32'h0000_00A5, 4'h1, 3, 32'h1234_5678);
    do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h0);
    do_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 32'h0BAD_F00D);
    rdata_bus = {$urandom, $urandom, $urandom, $urandom};
    req = 1'b1; we = 1'b0; addr = 32'h0000_0020; ready = 4'h0;
    step();
    req = 1'b0;
    repeat (3) begin
      chk("abort_pre_req", {28'd0, sreq}, 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_slv_req", {28'd0, sreq}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    chk("abort_rvalid2", {31'd0, rvalid}, 32'd0);
    do_txn(1'b0, 32'h8000_1000, 32'h0, 4'hF, 1, 32'hCAFE_0002);
`ifdef BUS_DECODER_TIMEOUT_EN
    req = 1'b1; we = 1'b0; addr = 32'h8000_2040; ready = 4'h0;
    step();
    req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_slv_req", {28'd0, sreq}, 32'h8);
      step();
    end
    chk("to_drop_req", {28'd0, sreq}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    chk("to_rvalid_early", {31'd0, rvalid}, 32'd0);
    step();
    chk("to_rvalid", {31'd0, rvalid}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    step();
    chk("to_busy_done", {31'd0, busy}, 32'd0);
`endif
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 255));
        1: a = 32'h8000_0800 + 32'($urandom_range(0, 3));
        2: a = 32'h8000_1000 + 32'($urandom_range(0, 3));
        3: a = 32'h8000_2000 + 32'($urandom_range(0, 4095));
        default: a = $urandom;
      endcase
      do_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
